// File: rtl/vga_layer_renderer.sv
// vga_layer_renderer: VGA timing generator plus a layered pixel compositor.
// Draws up to NOBJ enable-able rectangles over a border and a background
// colour, with fixed priority border > obj0 > ... > obj(NOBJ-1) > bg.
// All colour and object inputs are shadowed once per frame, so a frame is
// always drawn from one consistent set of values.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   bg_color     background colour
//   border_color border colour
//   obj_x/obj_y  per-object top-left corner, object i in bits [10i+9:10i]
//   obj_color    per-object colour, object i in bits [RGB_W*i +: RGB_W]
//   obj_en       per-object enable
//   hsync/vsync  active-low syncs, delayed to line up with rgb
//   video_on     high while the pixel on rgb lies in the active area
//   frame_start  one-clk pulse when the shadow registers load
//   rgb          pixel colour, zero outside the active area
//
// Pipeline (advances on pixel tick only): S1 counters -> S2 hit flags and
// sync/active flags -> S3 registered outputs. Outputs show the counter value
// of two ticks earlier.
module vga_layer_renderer #(
  parameter int RGB_W    = 9,
  parameter int NOBJ     = 4,
  parameter int OBJ_W    = 10,
  parameter int OBJ_H    = 100,
  parameter int BORDER_W = 10,
  parameter int TICK_DIV = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RGB_W-1:0]      bg_color,
  input  logic [RGB_W-1:0]      border_color,
  input  logic [NOBJ*10-1:0]    obj_x,
  input  logic [NOBJ*10-1:0]    obj_y,
  input  logic [NOBJ*RGB_W-1:0] obj_color,
  input  logic [NOBJ-1:0]       obj_en,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  video_on,
  output logic                  frame_start,
  output logic [RGB_W-1:0]      rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Coordinates are carried at 11 bits so object right/bottom edges never wrap.
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_LO   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_HI   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_LO   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_HI   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] OBJ_W11 = 11'(OBJ_W);
  localparam logic [10:0] OBJ_H11 = 11'(OBJ_H);

  // ---------------- pixel tick ----------------
  logic tick;

  generate
    if (TICK_DIV <= 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(TICK_DIV);
      logic [DW-1:0] div;
      assign tick = (div == DW'(TICK_DIV - 1));
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)    div <= '0;
        else if (tick) div <= '0;
        else           div <= div + DW'(1);
      end
    end
  endgenerate

  // ---------------- S1: counters and shadow load ----------------
  logic [10:0] h, v;
  logic        h_last, v_last, load;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);
  assign load   = tick && h_last && v_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? 11'd0 : v + 11'd1;
      end else begin
        h <= h + 11'd1;
      end
    end
  end

  logic [RGB_W-1:0]      sh_bg, sh_border;
  logic [NOBJ*10-1:0]    sh_x, sh_y;
  logic [NOBJ*RGB_W-1:0] sh_color;
  logic [NOBJ-1:0]       sh_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_bg       <= '0;
      sh_border   <= '0;
      sh_x        <= '0;
      sh_y        <= '0;
      sh_color    <= '0;
      sh_en       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (load) begin
        sh_bg     <= bg_color;
        sh_border <= border_color;
        sh_x      <= obj_x;
        sh_y      <= obj_y;
        sh_color  <= obj_color;
        sh_en     <= obj_en;
      end
    end
  end

  // ---------------- S2: hit detection ----------------
  logic            active_c, hs_c, vs_c, border_c;
  logic [NOBJ-1:0] hit_c;

  assign active_c = (h < H_ACT) && (v < V_ACT);
  assign hs_c     = !((h >= HS_LO) && (h < HS_HI));
  assign vs_c     = !((v >= VS_LO) && (v < VS_HI));

  generate
    if (BORDER_W > 0) begin : g_border
      localparam logic [10:0] BW    = 11'(BORDER_W);
      localparam logic [10:0] BX_HI = 11'(H_ACTIVE - BORDER_W);
      localparam logic [10:0] BY_HI = 11'(V_ACTIVE - BORDER_W);
      assign border_c = (h < BW) || (h >= BX_HI) || (v < BW) || (v >= BY_HI);
    end else begin : g_noborder
      assign border_c = 1'b0;
    end

    for (genvar gi = 0; gi < NOBJ; gi++) begin : g_obj
      logic [10:0] ox, oy;
      assign ox = {1'b0, sh_x[gi*10 +: 10]};
      assign oy = {1'b0, sh_y[gi*10 +: 10]};
      assign hit_c[gi] = sh_en[gi] &&
                         (h >= ox) && (h < ox + OBJ_W11) &&
                         (v >= oy) && (v < oy + OBJ_H11);
    end
  endgenerate

  logic            s2_active, s2_hs, s2_vs, s2_border;
  logic [NOBJ-1:0] s2_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_active <= 1'b0;
      s2_hs     <= 1'b1;
      s2_vs     <= 1'b1;
      s2_border <= 1'b0;
      s2_hit    <= '0;
    end else if (tick) begin
      s2_active <= active_c;
      s2_hs     <= hs_c;
      s2_vs     <= vs_c;
      s2_border <= border_c;
      s2_hit    <= hit_c;
    end
  end

  // ---------------- S3: priority mux and output registers ----------------
  logic [RGB_W-1:0] pix;

  // Walk from the lowest-priority object upward so the last match wins;
  // the border overrides every object and blanking overrides everything.
  always_comb begin
    pix = sh_bg;
    for (int i = NOBJ - 1; i >= 0; i--) begin
      if (s2_hit[i]) pix = sh_color[i*RGB_W +: RGB_W];
    end
    if (s2_border) pix = sh_border;
    if (!s2_active) pix = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb      <= '0;
      video_on <= 1'b0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
    end else if (tick) begin
      rgb      <= pix;
      video_on <= s2_active;
      hsync    <= s2_hs;
      vsync    <= s2_vs;
    end
  end

endmodule
